// File: rtl/rotation_finder.sv
// Sequential rotation search: finds the left/right rotation that maps original onto rotated,
// testing one candidate per clock behind a start/busy/done handshake.
module rotation_finder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] original,
  input  logic [WIDTH-1:0] rotated,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [7:0]       distance,
  output logic             direction
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [7:0] WIDTH_8 = 8'(WIDTH);
  localparam logic [7:0] HALF    = 8'(WIDTH / 2);
  localparam logic [7:0] LAST    = 8'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] target;
  logic [7:0]       count;
  logic [8:0]       encoded;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] value);
    return {value[WIDTH-2:0], value[WIDTH-1]};
  endfunction

  // Left distances past the half-way point are cheaper to express as a right rotation.
  // Returns {direction, distance}.
  function automatic logic [8:0] encode_distance(input logic [7:0] left_dist);
    logic [8:0] result;
    if (left_dist <= HALF) begin
      result = {1'b1, left_dist};
    end else begin
      result = {1'b0, WIDTH_8 - left_dist};
    end
    return result;
  endfunction

  assign encoded = encode_distance(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      candidate <= '0;
      target    <= '0;
      count     <= 8'd0;
      found     <= 1'b0;
      distance  <= 8'd0;
      direction <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            candidate <= original;
            target    <= rotated;
            count     <= 8'd0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          // candidate always holds original rotated left by count
          if (candidate == target) begin
            found     <= 1'b1;
            direction <= encoded[8];
            distance  <= encoded[7:0];
            state     <= DONE;
          end else if (count == LAST) begin
            found     <= 1'b0;
            direction <= 1'b0;
            distance  <= 8'd0;
            state     <= DONE;
          end else begin
            candidate <= rotl1(candidate);
            count     <= count + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rotation_finder.sv
// Directed and random checks of rotation_finder against an independent rotator model,
// using a queue of expected results popped at each done pulse.
module tb_rotation_finder;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 40;

  typedef struct packed {
    logic       found;
    logic [7:0] distance;
    logic       direction;
    logic [7:0] latency;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] original;
  logic [WIDTH-1:0] rotated;
  logic             busy;
  logic             done;
  logic             found;
  logic [7:0]       distance;
  logic             direction;

  int compared = 0;
  int mismatched = 0;
  exp_t sb_q[$];

  rotation_finder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .original  (original),
    .rotated   (rotated),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .distance  (distance),
    .direction (direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rotator: dir 1 = left, 0 = right
  function automatic logic [7:0] rotate(input logic [7:0] x, input logic [7:0] n, input logic dir);
    logic [15:0] dbl;
    logic [15:0] sh;
    dbl = {x, x};
    if (dir) begin
      sh = dbl << (n % 8);
      return sh[15:8];
    end else begin
      sh = dbl >> (n % 8);
      return sh[7:0];
    end
  endfunction

  function automatic exp_t model(input logic [7:0] o, input logic [7:0] r);
    exp_t e;
    e = '{found: 1'b0, distance: 8'd0, direction: 1'b0, latency: 8'(WIDTH)};
    for (int k = 0; k < WIDTH; k++) begin
      if (rotate(o, 8'(k), 1'b1) == r) begin
        e.found = 1'b1;
        e.latency = 8'(k + 1);
        if (k <= WIDTH / 2) begin
          e.direction = 1'b1;
          e.distance = 8'(k);
        end else begin
          e.direction = 1'b0;
          e.distance = 8'(WIDTH - k);
        end
        break;
      end
    end
    return e;
  endfunction

  task automatic run_search(input string tag, input logic [7:0] o, input logic [7:0] r,
                            input bit noisy, input exp_t e);
    int cycles;
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    original = o;
    rotated = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
    cycles = 0;
    while (cycles < MAX_WAIT) begin
      @(negedge clk);
      cycles++;
      if (done) break;
      if (noisy) begin
        start = 1'($urandom);
        original = 8'($urandom);
        rotated = 8'($urandom);
      end
    end
    if (noisy) start = 1'b1;
    got = sb_q.pop_front();
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(cycles), 32'(got.latency));
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    check({tag, ".found"}, 32'(found), 32'(got.found));
    check({tag, ".distance"}, 32'(distance), 32'(got.distance));
    check({tag, ".direction"}, 32'(direction), 32'(got.direction));
    if (found) check({tag, ".rerotate"}, 32'(rotate(o, distance, direction)), 32'(r));
    @(negedge clk);
    start = 1'b0;
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".idle_not_busy"}, 32'(busy), 32'd0);
    if (noisy) begin
      repeat (3) begin
        @(negedge clk);
        check({tag, ".no_extra_done"}, 32'(done), 32'd0);
      end
      check({tag, ".found_held"}, 32'(found), 32'(got.found));
      check({tag, ".distance_held"}, 32'(distance), 32'(got.distance));
    end
  endtask

  initial begin
    logic [7:0] ro;
    logic [7:0] rr;
    logic [7:0] rd;
    logic       rdir;
    rst_n = 1'b0;
    start = 1'b0;
    original = '0;
    rotated = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.found", 32'(found), 32'd0);
    check("reset.distance", 32'(distance), 32'd0);
    check("reset.direction", 32'(direction), 32'd0);
    rst_n = 1'b1;

    run_search("left3", 8'h01, 8'h08, 1'b0, '{1'b1, 8'd3, 1'b1, 8'd4});
    run_search("right1", 8'h01, 8'h80, 1'b0, '{1'b1, 8'd1, 1'b0, 8'd8});
    run_search("tie4", 8'h01, 8'h10, 1'b0, '{1'b1, 8'd4, 1'b1, 8'd5});
    run_search("zero", 8'h3C, 8'h3C, 1'b0, '{1'b1, 8'd0, 1'b1, 8'd1});
    run_search("nomatch", 8'hA5, 8'h00, 1'b0, '{1'b0, 8'd0, 1'b0, 8'd8});
    run_search("periodic", 8'hAA, 8'h55, 1'b0, '{1'b1, 8'd1, 1'b1, 8'd2});
    run_search("noisy", 8'h03, 8'hC0, 1'b1, '{1'b1, 8'd2, 1'b0, 8'd7});

    // Abort a search with an asynchronous reset once count reaches 3
    @(negedge clk);
    original = 8'h01;
    rotated = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.found", 32'(found), 32'd0);
    check("abort.distance", 32'(distance), 32'd0);
    check("abort.direction", 32'(direction), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("abort.no_done", 32'(done), 32'd0);
    end
    run_search("after_abort", 8'h01, 8'h08, 1'b0, '{1'b1, 8'd3, 1'b1, 8'd4});

    for (int i = 0; i < 12; i++) begin
      ro = 8'($urandom);
      rd = 8'($urandom_range(0, 7));
      rdir = 1'($urandom);
      rr = rotate(ro, rd, rdir);
      run_search("random", ro, rr, 1'b0, model(ro, rr));
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
